// File: rtl/std_cache_bypass_pkg.sv
// Request/response types shared between the cache bypass arbiter and the
// bypass responder.
//   bypass_req_t : req, reqtype, amo, id, addr, wdata, we, be, size
//   bypass_rsp_t : gnt, valid, rdata
package std_cache_bypass_pkg;

    typedef struct packed {
        logic        req;
        logic        reqtype;
        logic [3:0]  amo;
        logic [3:0]  id;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [7:0]  be;
        logic [1:0]  size;
    } bypass_req_t;

    typedef struct packed {
        logic        gnt;
        logic        valid;
        logic [63:0] rdata;
    } bypass_rsp_t;

endpackage

// File: rtl/std_cache_bypass_responder.sv
// Memory-side responder for the std cache bypass port (uncacheable / I/O).
// Each granted bypass request becomes exactly one single-beat access on a
// req/gnt/rvalid memory port. Only one transaction is in flight at a time.
// A watchdog turns a missing memory response into an error response, and a
// saturating counter tracks completed responses.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   bypass_req_i        request from the cache (amo/reqtype/id/size unused)
//   bypass_rsp_o        gnt (combinational, IDLE only), valid (1 cycle), rdata
//   mem_req_o/gnt_i     memory request handshake
//   mem_we_o, mem_addr_o (8-byte aligned), mem_wdata_o, mem_be_o
//   mem_rvalid_i, mem_rdata_i   memory response
//   timeout_o           one-cycle pulse when the watchdog expires
//   txn_cnt_o           saturating count of completed responses
module std_cache_bypass_responder
    import std_cache_bypass_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024,
    parameter int unsigned CNT_WIDTH      = 32'd32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  bypass_req_t          bypass_req_i,
    output bypass_rsp_t          bypass_rsp_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [63:0]          mem_addr_o,
    output logic [63:0]          mem_wdata_o,
    output logic [7:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] txn_cnt_o
);

    // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned    WD_W     = (TIMEOUT_CYCLES > 32'd1) ? 32'($clog2(TIMEOUT_CYCLES)) : 32'd1;
    localparam bit             WD_EN    = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [63:0]    ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  we_r;
    logic [63:3]           addr_r;
    logic [63:0]           wdata_r;
    logic [7:0]            be_r;
    logic [63:0]           rdata_r;
    logic [WD_W-1:0]       wd_r;
    logic [CNT_WIDTH-1:0]  txn_cnt_r;

    logic                  gnt_s;
    logic                  issue_s;
    logic                  wd_expire_s;
    logic                  rsp_load_s;
    logic [63:0]           rsp_data_s;

    // Request attributes and sub-doubleword address bits are not needed:
    // every access is a full-lane load/store and the requester aligns bytes.
    logic unused_s;
    assign unused_s = ^{bypass_req_i.reqtype, bypass_req_i.amo, bypass_req_i.id,
                        bypass_req_i.size, bypass_req_i.addr[2:0]};

    // Next-state decode, grant, watchdog expiry and response data selection.
    always_comb begin
        state_nxt_s = state_r;
        gnt_s       = 1'b0;
        wd_expire_s = 1'b0;
        rsp_load_s  = 1'b0;
        rsp_data_s  = 64'd0;
        case (state_r)
            ST_IDLE: begin
                if (bypass_req_i.req) begin
                    gnt_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A response arriving in the expiry cycle wins over the watchdog.
                if (mem_rvalid_i) begin
                    rsp_load_s  = 1'b1;
                    rsp_data_s  = we_r ? 64'd0 : mem_rdata_i;
                    state_nxt_s = ST_RESP;
                end else if (WD_EN && (wd_r == WD_LAST)) begin
                    wd_expire_s = 1'b1;
                    rsp_load_s  = 1'b1;
                    rsp_data_s  = ERR_DATA;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the granted request; held stable for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_r    <= 1'b0;
            addr_r  <= 61'd0;
            wdata_r <= 64'd0;
            be_r    <= 8'd0;
        end else if (gnt_s) begin
            we_r    <= bypass_req_i.we;
            addr_r  <= bypass_req_i.addr[63:3];
            wdata_r <= bypass_req_i.wdata;
            be_r    <= bypass_req_i.be;
        end
    end

    // Watchdog: cleared on memory grant, counts every cycle spent in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_r <= '0;
        end else if ((state_r == ST_ISSUE) && mem_gnt_i) begin
            wd_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wd_r <= wd_r + WD_W'(1);
        end
    end

    // Response data register (memory data, zero for writes, or error pattern).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r <= 64'd0;
        end else if (rsp_load_s) begin
            rdata_r <= rsp_data_s;
        end
    end

    // Completed-response counter, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_cnt_r <= '0;
        end else if ((state_r == ST_RESP) && (txn_cnt_r != {CNT_WIDTH{1'b1}})) begin
            txn_cnt_r <= txn_cnt_r + CNT_WIDTH'(1);
        end
    end

    // Memory-side outputs are only driven while the request is being issued.
    assign issue_s     = (state_r == ST_ISSUE);
    assign mem_req_o   = issue_s;
    assign mem_we_o    = issue_s & we_r;
    assign mem_addr_o  = issue_s ? {addr_r, 3'b000} : 64'd0;
    assign mem_wdata_o = issue_s ? wdata_r : 64'd0;
    assign mem_be_o    = issue_s ? be_r : 8'd0;

    assign bypass_rsp_o = '{gnt: gnt_s, valid: (state_r == ST_RESP), rdata: rdata_r};
    assign timeout_o    = wd_expire_s;
    assign txn_cnt_o    = txn_cnt_r;

endmodule

// File: tb/tb_std_cache_bypass_responder.sv
// Scoreboard bench for std_cache_bypass_responder: directed stimulus pushes
// hand-computed expected responses; a monitor pops and compares on rsp.valid.
module tb_std_cache_bypass_responder;
    import std_cache_bypass_pkg::*;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst;
    bypass_req_t   breq;
    bypass_rsp_t   brsp;
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_we;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_be;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;
    logic          timeout;
    logic [CW-1:0] txn_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0]   exp_rdata_q[$];
    logic [CW-1:0] exp_cnt_q[$];

    std_cache_bypass_responder #(
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bypass_req_i (breq),
        .bypass_rsp_o (brsp),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .timeout_o    (timeout),
        .txn_cnt_o    (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] rd, input logic [CW-1:0] cnt);
        exp_rdata_q.push_back(rd);
        exp_cnt_q.push_back(cnt);
    endtask

    // Monitor: every response must match the oldest expected entry; the
    // counter is checked on the cycle after the response.
    logic [63:0]   mon_rd;
    logic [CW-1:0] mon_cnt;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && brsp.valid) begin
                if (exp_rdata_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got valid=1 rdata=0x%0h expected no response", brsp.rdata);
                end else begin
                    mon_rd  = exp_rdata_q.pop_front();
                    mon_cnt = exp_cnt_q.pop_front();
                    chk("rsp_rdata", brsp.rdata, mon_rd);
                    @(negedge clk);
                    chk("txn_cnt", 64'(txn_cnt), 64'(mon_cnt));
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL sim_timeout: got no end of test expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst        = 1'b1;
        breq       = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        #12;
        chk("rst_gnt",     64'(brsp.gnt),   64'd0);
        chk("rst_valid",   64'(brsp.valid), 64'd0);
        chk("rst_rdata",   brsp.rdata,      64'd0);
        chk("rst_mem_req", 64'(mem_req),    64'd0);
        chk("rst_mem_we",  64'(mem_we),     64'd0);
        chk("rst_addr",    mem_addr,        64'd0);
        chk("rst_wdata",   mem_wdata,       64'd0);
        chk("rst_be",      64'(mem_be),     64'd0);
        chk("rst_timeout", 64'(timeout),    64'd0);
        chk("rst_cnt",     64'(txn_cnt),    64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Read: unaligned address, immediate grant, rvalid next cycle.
        breq.req  = 1'b1;
        breq.addr = 64'h0000_0000_8000_0013;
        breq.we   = 1'b0;
        breq.be   = 8'hFF;
        breq.amo  = 4'h3;
        push(64'h1122_3344_5566_7788, 2'd1);
        @(negedge clk);
        chk("read_gnt", 64'(brsp.gnt), 64'd1);
        @(posedge clk); #1 breq.req = 1'b0; breq.amo = 4'h0; mem_gnt = 1'b1;
        @(negedge clk);
        chk("read_mem_req",  64'(mem_req), 64'd1);
        chk("read_mem_addr", mem_addr,     64'h0000_0000_8000_0010);
        chk("read_mem_we",   64'(mem_we),  64'd0);
        @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = 64'd0;
        @(negedge clk);
        chk("read_valid_cycle3", 64'(brsp.valid), 64'd1);
        @(posedge clk); #1;

        // Write: grant withheld for 4 cycles; request must stay stable.
        breq.req   = 1'b1;
        breq.we    = 1'b1;
        breq.addr  = 64'h0000_0000_1000_000C;
        breq.wdata = 64'h0000_0000_0000_A5A5;
        breq.be    = 8'h03;
        push(64'd0, 2'd2);
        @(posedge clk); #1 breq.req = 1'b0; breq.wdata = 64'hFFFF; breq.be = 8'hFF; breq.addr = 64'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_gnt = 1'b1;
            @(negedge clk);
            chk("wr_mem_req",   64'(mem_req), 64'd1);
            chk("wr_mem_addr",  mem_addr,     64'h0000_0000_1000_0008);
            chk("wr_mem_wdata", mem_wdata,    64'h0000_0000_0000_A5A5);
            chk("wr_mem_be",    64'(mem_be),  64'h03);
            chk("wr_mem_we",    64'(mem_we),  64'd1);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("wr_req_released", 64'(mem_req), 64'd0);
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
        @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = 64'd0;
        @(negedge clk);
        chk("wr_valid", 64'(brsp.valid), 64'd1);
        @(posedge clk); #1;

        // Back-to-back: req held high across two transactions.
        breq.we = 1'b0;
        push(64'h0A0A_0A0A_0A0A_0A0A, 2'd3);
        push(64'h0B0B_0B0B_0B0B_0B0B, 2'd3);
        for (int c = 0; c < 8; c++) begin
            mem_gnt    = (c % 4 == 1);
            mem_rvalid = (c % 4 == 2);
            mem_rdata  = (c < 4) ? 64'h0A0A_0A0A_0A0A_0A0A : 64'h0B0B_0B0B_0B0B_0B0B;
            breq.req   = (c < 5);
            breq.addr  = (c < 4) ? 64'h40 : 64'h48;
            @(negedge clk);
            chk("b2b_gnt",   64'(brsp.gnt),   64'(c % 4 == 0));
            chk("b2b_valid", 64'(brsp.valid), 64'(c % 4 == 3));
            if (c % 4 == 1) chk("b2b_addr", mem_addr, (c < 4) ? 64'h40 : 64'h48);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; breq.req = 1'b0;

        // Timeout: no rvalid after the grant.
        breq.req  = 1'b1;
        breq.addr = 64'h2000;
        push(64'hDEAD_BEEF_DEAD_BEEF, 2'd3);
        @(negedge clk);
        chk("to_gnt", 64'(brsp.gnt), 64'd1);
        @(posedge clk); #1 breq.req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_pulse",   64'(timeout),    64'(k == 8));
            chk("to_novalid", 64'(brsp.valid), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_resp_valid",   64'(brsp.valid), 64'd1);
        chk("to_pulse_single", 64'(timeout),    64'd0);
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("to_cnt_after_stray", 64'(txn_cnt), 64'd3);

        // Reset while waiting for the memory response.
        @(posedge clk); #1 breq.req = 1'b1; breq.addr = 64'h3000;
        @(posedge clk); #1 breq.req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt",     64'(txn_cnt),    64'd0);
        chk("arst_valid",   64'(brsp.valid), 64'd0);
        chk("arst_mem_req", 64'(mem_req),    64'd0);
        chk("arst_timeout", 64'(timeout),    64'd0);
        @(posedge clk); #1 rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h7777;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", 64'(brsp.valid), 64'd0);
        end
        chk("arst_cnt_hold", 64'(txn_cnt), 64'd0);

        // Normal read after reset: counter restarts at 1.
        @(posedge clk); #1 breq.req = 1'b1; breq.addr = 64'h0000_0000_0000_5008;
        push(64'h5555_AAAA_5555_AAAA, 2'd1);
        @(posedge clk); #1 breq.req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_rdata_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
